// File: rtl/chaser_pkg.sv
// Shared definitions for the segment chaser display.
//   mode_e          : run-mode encodings sampled on each step tick
//   dir_e           : ping-pong travel direction
//   seg_onehot_low  : active-low one-hot segment pattern for chase position p
package chaser_pkg;

   localparam int unsigned SEG_MAX = 32;

   typedef enum logic [1:0] {
      MODE_FWD  = 2'b00,
      MODE_REV  = 2'b01,
      MODE_PING = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_e;

   // Position 0 maps to the MSB of the segment bus (segment a); all other bits stay high.
   function automatic logic [SEG_MAX-1:0] seg_onehot_low(input int p, input int segw);
      logic [SEG_MAX-1:0] r;
      r = '1;
      for (int i = 0; i < int'(SEG_MAX); i++) begin
         if (i == segw - 1 - p) r[i] = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and wraps.
//   clk  : system clock
//   re   : asynchronous active-low reset
//   tick : high for the single cycle in which the count equals DIV-1
module tick_gen #(
   parameter int unsigned DIV = 2
) (
   input  logic clk,
   input  logic re,
   output logic tick
);

   localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge re) begin
      if (!re) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/chaser_scan_display.sv
// Multiplexed common-anode chaser: one lit segment per digit walks through STEPS
// positions, each digit offset by PHASE steps, with forward/reverse/ping-pong/hold.
//   clk  : system clock
//   re   : asynchronous active-low reset (blanks display, pos=0)
//   en   : 1 lets the chase advance on step ticks; scanning always runs
//   mode : 00 fwd, 01 rev, 10 ping-pong, 11 hold (sampled on step ticks)
//   an   : digit enables, active-low
//   out  : segment drive, active-low
//   pos  : current base chase position
module chaser_scan_display
   import chaser_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned SEGW     = 8,
   parameter int unsigned STEPS    = 7,
   parameter int unsigned PHASE    = 2,
   parameter int unsigned STEP_DIV = 8388608,
   parameter int unsigned SCAN_DIV = 32768
) (
   input  logic                       clk,
   input  logic                       re,
   input  logic                       en,
   input  logic [1:0]                 mode,
   output logic [DIGITS-1:0]          an,
   output logic [SEGW-1:0]            out,
   output logic [$clog2(STEPS)-1:0]   pos
);

   localparam int unsigned PW = $clog2(STEPS);
   localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   // One extra bit so STEPS itself is representable as the modulus.
   localparam int unsigned SW = $clog2(STEPS * DIGITS) + 1;
   localparam logic [PW-1:0] LAST     = PW'(STEPS - 1);
   localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);

   logic step_tick;
   logic scan_tick;

   tick_gen #(.DIV(STEP_DIV)) u_step (.clk(clk), .re(re), .tick(step_tick));
   tick_gen #(.DIV(SCAN_DIV)) u_scan (.clk(clk), .re(re), .tick(scan_tick));

   logic [PW-1:0]     pos_q, pos_d;
   dir_e              dir_q, dir_d;
   mode_e             last_mode_q, last_mode_d;
   logic [DW-1:0]     dig_q, dig_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [SEGW-1:0]   out_q, out_d;

   dir_e              ping_dir_c;
   mode_e             mode_c;
   logic [SW-1:0]     sum_c;
   logic [PW-1:0]     p_c;

   // Next position/direction and scan registers.
   always_comb begin
      pos_d       = pos_q;
      dir_d       = dir_q;
      last_mode_d = last_mode_q;
      dig_d       = dig_q;
      an_d        = an_q;
      out_d       = out_q;
      mode_c      = mode_e'(mode);
      ping_dir_c  = dir_q;
      sum_c       = '0;
      p_c         = '0;

      if (step_tick && en) begin
         last_mode_d = mode_c;
         case (mode_c)
            MODE_FWD: pos_d = (pos_q == LAST) ? '0 : pos_q + PW'(1);
            MODE_REV: pos_d = (pos_q == '0) ? LAST : pos_q - PW'(1);
            MODE_PING: begin
               // Fresh entry into ping-pong: head up unless already at the top end.
               if (last_mode_q != MODE_PING) ping_dir_c = (pos_q == LAST) ? DIR_DN : DIR_UP;
               if (ping_dir_c == DIR_UP) begin
                  if (pos_q == LAST) begin
                     pos_d = LAST - PW'(1);
                     dir_d = DIR_DN;
                  end else begin
                     pos_d = pos_q + PW'(1);
                     dir_d = DIR_UP;
                  end
               end else begin
                  if (pos_q == '0) begin
                     pos_d = PW'(1);
                     dir_d = DIR_UP;
                  end else begin
                     pos_d = pos_q - PW'(1);
                     dir_d = DIR_DN;
                  end
               end
            end
            default: ;
         endcase
      end

      // Digit select and segments register together from the pre-update pos.
      if (scan_tick) begin
         dig_d = (dig_q == LAST_DIG) ? '0 : dig_q + DW'(1);
         an_d  = ~(DIGITS'(1) << dig_d);
         sum_c = SW'(pos_q) + SW'(dig_d) * SW'(PHASE);
         p_c   = PW'(sum_c % SW'(STEPS));
         out_d = SEGW'(seg_onehot_low(int'(p_c), int'(SEGW)));
      end
   end

   always_ff @(posedge clk or negedge re) begin
      if (!re) begin
         pos_q       <= '0;
         dir_q       <= DIR_UP;
         last_mode_q <= MODE_FWD;
         dig_q       <= '0;
         an_q        <= '1;
         out_q       <= '1;
      end else begin
         pos_q       <= pos_d;
         dir_q       <= dir_d;
         last_mode_q <= last_mode_d;
         dig_q       <= dig_d;
         an_q        <= an_d;
         out_q       <= out_d;
      end
   end

   assign an  = an_q;
   assign out = out_q;
   assign pos = pos_q;

endmodule

// File: tb/tb_chaser_scan_display.sv
// Randomised bench for chaser_scan_display against a behavioural model.
module tb_chaser_scan_display;

   localparam int DIGITS = 4;
   localparam int SEGW   = 8;
   localparam int STEPS  = 7;
   localparam int PHASE  = 2;
   localparam int SD     = 8;
   localparam int SC     = 2;
   localparam int PP     = 2 * (STEPS - 1);

   logic       clk = 1'b0;
   logic       re  = 1'b0;
   logic       en  = 1'b1;
   logic [1:0] mode = 2'b00;
   logic [DIGITS-1:0] an;
   logic [SEGW-1:0]   out;
   logic [2:0]        pos;

   chaser_scan_display #(
      .DIGITS(DIGITS), .SEGW(SEGW), .STEPS(STEPS), .PHASE(PHASE),
      .STEP_DIV(SD), .SCAN_DIV(SC)
   ) dut (
      .clk(clk), .re(re), .en(en), .mode(mode), .an(an), .out(out), .pos(pos)
   );

   always #5 clk = ~clk;

   // Model: edges since release, base position, ping-pong triangle phase k.
   int m_n, m_pos, m_d, m_k, m_last_mode;
   logic [DIGITS-1:0] m_an;
   logic [SEGW-1:0]   m_out;
   int old_pos;
   bit st, sc;

   always @(posedge clk or negedge re) begin
      if (!re) begin
         m_n = 0; m_pos = 0; m_d = 0; m_k = 0; m_last_mode = 0;
         m_an = '1; m_out = '1;
      end else begin
         old_pos = m_pos;
         st = (m_n % SD) == SD - 1;
         sc = (m_n % SC) == SC - 1;
         m_n++;
         if (sc) begin
            m_d   = (m_d + 1) % DIGITS;
            m_an  = 4'hF ^ (4'h1 << m_d);
            m_out = 8'hFF ^ (8'h80 >> ((old_pos + m_d * PHASE) % STEPS));
         end
         if (st && en) begin
            case (mode)
               2'd0: m_pos = (m_pos + 1) % STEPS;
               2'd1: m_pos = (m_pos + STEPS - 1) % STEPS;
               2'd2: begin
                  if (m_last_mode != 2) m_k = m_pos;
                  m_k   = (m_k + 1) % PP;
                  m_pos = (m_k < STEPS) ? m_k : PP - m_k;
               end
               default: ;
            endcase
            m_last_mode = int'(mode);
         end
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic run(input int k);
      repeat (k) begin
         @(negedge clk);
         check("pos", 32'(pos), 32'(m_pos));
         check("an",  32'(an),  32'(m_an));
         check("out", 32'(out), 32'(m_out));
      end
   endtask

   task automatic check_blank(input string tag);
      check({tag, "_an"},  32'(an),  32'h0000_000F);
      check({tag, "_out"}, 32'(out), 32'h0000_00FF);
      check({tag, "_pos"}, 32'(pos), 32'h0);
   endtask

   task automatic run_until_pos(input int p, input int phase_mod);
      int budget;
      budget = 300;
      while (!(m_pos == p && (phase_mod < 0 || (m_n % SD) == phase_mod)) && budget > 0) begin
         run(1);
         budget--;
      end
      check("reach_target", 32'(budget > 0), 32'h1);
   endtask

   initial begin
      // Reset and release.
      re = 1'b0; en = 1'b1; mode = 2'b00;
      repeat (3) @(negedge clk);
      check_blank("reset");
      re = 1'b1;
      run(2);
      check("dig1_an",  32'(an),  32'h0000_000D);
      check("dig1_out", 32'(out), 32'h0000_00DF);
      run(5);
      check("pre_tick_pos", 32'(pos), 32'h0);
      run(1);
      check("first_tick_pos", 32'(pos), 32'h1);
      run(60);

      // Reverse from 0.
      run_until_pos(0, 7);
      mode = 2'b01;
      run(30);

      // Ping-pong entered at 5.
      mode = 2'b00;
      run_until_pos(5, 7);
      mode = 2'b10;
      run(130);

      // Frozen position, scanning continues.
      mode = 2'b11; run(40);
      mode = 2'b00; en = 1'b0; run(40);
      en = 1'b1;

      // Asynchronous reset mid-step at counter=5, pos=3.
      run_until_pos(3, 5);
      #1 re = 1'b0;
      #1 check_blank("async_rst");
      run(3);
      re = 1'b1;
      run(20);

      // Random modes, enables and occasional resets.
      for (int i = 0; i < 60; i++) begin
         mode = 2'($urandom_range(0, 3));
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 11) == 0) begin
            #2 re = 1'b0;
            #1 check_blank("rand_rst");
            run(2);
            re = 1'b1;
         end
         run($urandom_range(1, 40));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
